elevator_call_panel: RTL and testbench
======================================

// Module: elevator_call_panel
// PURPOSE
//  Request-issuing side of the elevator interface. Latches car and hall button presses into a pending bitmap.
//  Selects one target floor with a SCAN policy (keep direction while requests remain ahead) and offers it
//  to the motion controller over a valid/ready handshake. Clears served requests on the controller's arrival indication.
//  Sits between the button/lamp I/O and the elevator motion controller.
// PARAMETERS
//  NUM_FLOORS       5   number of floors; buttons/lamps are one bit per floor
//  FLOOR_W          3   floor index width; NUM_FLOORS <= 2**FLOOR_W
//  DEBOUNCE_CYCLES  4   stable-high cycles required per button (used only with CALL_PANEL_DEBOUNCE_EN)
// PORTS
//  clk         in   1           single clock; all logic rising-edge
//  reset       in   1           synchronous, active-high
//  btn         in   NUM_FLOORS  raw button levels, bit i = floor i, active high
//  cur_floor   in   FLOOR_W     controller's current floor
//  at_floor    in   1           1-cycle pulse: controller stopped at cur_floor
//  req_ready   in   1           controller accepts req_floor this cycle
//  req_valid   out  1           req_floor valid
//  req_floor   out  FLOOR_W     target floor offered to controller
//  dir_up      out  1           current scan direction (1 = up)
//  pending     out  NUM_FLOORS  outstanding requests (drives button lamps)
//  served      out  1           1-cycle pulse when a pending bit is cleared
//  served_floor out FLOOR_W     floor cleared with served
// BEHAVIOUR
//  Reset (sync): pending=0, req_valid=0, req_floor=0, dir_up=1, served=0, served_floor=0, state=IDLE, edge regs=0.
//  Press detect: a rising edge of btn[i] (registered previous level) sets pending[i] on the next edge.
//   A held button sets it once only.
//  Clear: at_floor && cur_floor<NUM_FLOORS && pending[cur_floor] -> clear that bit; served=1, served_floor=cur_floor.
//   Applies in any state. Same-cycle press and clear of the same floor: clear wins.
//  cur_floor >= NUM_FLOORS: ignored for clear and for target selection (treated as floor 0 for distance).
//  FSM states (encodings in package): IDLE, ISSUE, WAIT_ARRIVE.
//   IDLE: if pending != 0, pick target and register req_floor. Set req_valid=1 and go to ISSUE.
//   ISSUE: req_valid held and req_floor stable until req_ready. On req_valid&&req_ready: req_valid=0, go to WAIT_ARRIVE.
//   WAIT_ARRIVE: at_floor && cur_floor==req_floor -> go to IDLE, with the bit cleared as above.
//  Request withdrawn in ISSUE (bit cleared by an arrival elsewhere): keep offering until accepted; no retraction.
//  Target pick (from registered pending, cur_floor, dir_up):
//   1. pending[cur_floor] -> that floor.
//   2. Otherwise the nearest pending floor strictly ahead in dir_up.
//   3. Otherwise flip dir_up and take the nearest in the new direction.
//   dir_up updates in the same cycle req_floor is registered.
//  Latency: btn rises at edge n -> pending at n+1 -> req_valid at n+2 (from IDLE).
//  Arrival pulse at edge m -> pending bit low and served high at m+1; the next request can be valid at m+2.
//  Width rules: floor compares are unsigned FLOOR_W; no wrap-around. Floor 0 and NUM_FLOORS-1 end the scan.
// CONFIGURATION
//  CALL_PANEL_DEBOUNCE_EN defined: per-button counter. btn[i] counts as high only after DEBOUNCE_CYCLES
//   consecutive high samples; any low sample resets the count. The press edge is taken on the debounced level,
//   so latency grows by DEBOUNCE_CYCLES.
//  Undefined: raw btn goes directly to edge detect; no counters are instantiated.
// STRUCTURE
//  Package elevator_pkg: FSM state encodings (IDLE/ISSUE/WAIT_ARRIVE), default NUM_FLOORS/FLOOR_W, floor type width.
//  Sub-module elevator_btn_debounce: one instance per button, generated only under CALL_PANEL_DEBOUNCE_EN.
//  Target pick is a combinational function inside this module.
// TESTING
//  1. reset; cur_floor=0; pulse btn[3] -> pending=5'b01000 at n+1; req_valid=1, req_floor=3, dir_up=1 at n+2.
//  2. req_ready low 5 cycles -> req_valid and req_floor=3 stable. ready=1 -> valid drops next cycle.
//     Then at_floor, cur_floor=3 -> pending[3]=0, served=1, served_floor=3.
//  3. cur_floor=2, dir_up=1, pending={0,1,4} -> req_floor=4. After serving 4 -> dir_up=0, req_floor=1, then 0.
//  4. btn[2] held high 20 cycles -> pending[2] set once; after it is served, still held -> no re-set until release and re-press.
//  5. at_floor at cur_floor=2 in the same cycle btn[2] rises -> pending[2] stays 0, served=1.
//  6. reset asserted in WAIT_ARRIVE with pending=5'b10110 -> next cycle all outputs at reset values.
//     Run with and without CALL_PANEL_DEBOUNCE_EN: a 3-cycle glitch on btn[1] is ignored with DEBOUNCE_CYCLES=4.

Source files
------------

// File: rtl/elevator_pkg.sv
// Shared definitions for the elevator call panel: FSM encodings and default sizing.
package elevator_pkg;

  localparam int DEF_NUM_FLOORS      = 5;
  localparam int DEF_FLOOR_W         = 3;
  localparam int DEF_DEBOUNCE_CYCLES = 4;

  typedef logic [DEF_FLOOR_W-1:0] floor_t;

  typedef enum logic [1:0] {
    ST_IDLE        = 2'd0,
    ST_ISSUE       = 2'd1,
    ST_WAIT_ARRIVE = 2'd2
  } panel_state_e;

endpackage

// File: rtl/elevator_btn_debounce.sv
// Single-button debouncer: level goes high after DEBOUNCE_CYCLES consecutive high samples.
module elevator_btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic level
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);

  logic [CNT_W-1:0] cnt;

  // Saturates at CNT_MAX so a held button stays debounced-high.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (!btn) begin
      cnt <= '0;
    end else if (cnt != CNT_MAX) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign level = (cnt == CNT_MAX);

endmodule

// File: rtl/elevator_call_panel.sv
// Elevator call panel: latches button presses, picks a SCAN target, offers it over valid/ready.
// Optional per-button debounce is enabled with the CALL_PANEL_DEBOUNCE_EN macro.
module elevator_call_panel
  import elevator_pkg::*;
#(
  parameter int NUM_FLOORS = DEF_NUM_FLOORS,
`ifdef CALL_PANEL_DEBOUNCE_EN
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
`endif
  parameter int FLOOR_W = DEF_FLOOR_W
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_FLOORS-1:0] btn,
  input  logic [FLOOR_W-1:0]    cur_floor,
  input  logic                  at_floor,
  input  logic                  req_ready,
  output logic                  req_valid,
  output logic [FLOOR_W-1:0]    req_floor,
  output logic                  dir_up,
  output logic [NUM_FLOORS-1:0] pending,
  output logic                  served,
  output logic [FLOOR_W-1:0]    served_floor
);

  // Handshake: req_floor is offered while req_valid is high and is held stable
  // until the cycle req_valid && req_ready; a raised request is never retracted.

  localparam logic [FLOOR_W-1:0] LAST_FLOOR = FLOOR_W'(NUM_FLOORS - 1);

  panel_state_e state_q, state_d;

  logic [NUM_FLOORS-1:0] btn_lvl;
  logic [NUM_FLOORS-1:0] btn_prev;
  logic [NUM_FLOORS-1:0] press;
  logic [NUM_FLOORS-1:0] clr_mask;
  logic                  req_valid_d;
  logic [FLOOR_W-1:0]    req_floor_d;
  logic                  dir_up_d;
  logic [FLOOR_W:0]      pick;

`ifdef CALL_PANEL_DEBOUNCE_EN
  for (genvar g = 0; g < NUM_FLOORS; g++) begin : g_debounce
    elevator_btn_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk   (clk),
      .reset (reset),
      .btn   (btn[g]),
      .level (btn_lvl[g])
    );
  end
`else
  assign btn_lvl = btn;
`endif

  assign press = btn_lvl & ~btn_prev;

  // SCAN pick, returned as {direction, floor}. An out-of-range current floor
  // never matches rule 1 and is measured from floor 0.
  function automatic logic [FLOOR_W:0] pick_target(
    input logic [NUM_FLOORS-1:0] pend,
    input logic [FLOOR_W-1:0]    cur,
    input logic                  up
  );
    logic                 cur_ok;
    logic                 here;
    logic                 found_up;
    logic                 found_dn;
    logic [FLOOR_W-1:0]   cur_eff;
    logic [FLOOR_W-1:0]   near_up;
    logic [FLOOR_W-1:0]   near_dn;
    logic [FLOOR_W-1:0]   lowest;
    logic [FLOOR_W:0]     result;
    cur_ok   = (cur <= LAST_FLOOR);
    cur_eff  = cur_ok ? cur : '0;
    here     = 1'b0;
    found_up = 1'b0;
    found_dn = 1'b0;
    near_up  = '0;
    near_dn  = '0;
    lowest   = '0;
    for (int i = NUM_FLOORS - 1; i >= 0; i--) begin
      if (pend[i]) lowest = FLOOR_W'(i);
      if (pend[i] && (FLOOR_W'(i) > cur_eff)) begin
        found_up = 1'b1;
        near_up  = FLOOR_W'(i);
      end
    end
    for (int i = 0; i < NUM_FLOORS; i++) begin
      if (pend[i] && (FLOOR_W'(i) < cur_eff)) begin
        found_dn = 1'b1;
        near_dn  = FLOOR_W'(i);
      end
      if (pend[i] && cur_ok && (FLOOR_W'(i) == cur)) here = 1'b1;
    end
    if (here)                  result = {up, cur};
    else if (up && found_up)   result = {1'b1, near_up};
    else if (up && found_dn)   result = {1'b0, near_dn};
    else if (!up && found_dn)  result = {1'b0, near_dn};
    else if (!up && found_up)  result = {1'b1, near_up};
    else                       result = {up, lowest};
    return result;
  endfunction

  // A press landing in the same cycle as an arrival at that floor is served at once.
  always_comb begin
    clr_mask = '0;
    for (int i = 0; i < NUM_FLOORS; i++) begin
      clr_mask[i] = at_floor && (cur_floor == FLOOR_W'(i)) && (pending[i] || press[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      btn_prev     <= '0;
      pending      <= '0;
      served       <= 1'b0;
      served_floor <= '0;
    end else begin
      btn_prev <= btn_lvl;
      pending  <= (pending | press) & ~clr_mask;
      served   <= |clr_mask;
      if (|clr_mask) served_floor <= cur_floor;
    end
  end

  always_comb begin
    state_d     = state_q;
    req_valid_d = req_valid;
    req_floor_d = req_floor;
    dir_up_d    = dir_up;
    pick        = pick_target(pending, cur_floor, dir_up);
    case (state_q)
      ST_IDLE: begin
        if (|pending) begin
          req_floor_d = pick[FLOOR_W-1:0];
          dir_up_d    = pick[FLOOR_W];
          req_valid_d = 1'b1;
          state_d     = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (req_ready) begin
          req_valid_d = 1'b0;
          state_d     = ST_WAIT_ARRIVE;
        end
      end
      ST_WAIT_ARRIVE: begin
        if (at_floor && (cur_floor == req_floor)) state_d = ST_IDLE;
      end
      default: begin
        req_valid_d = 1'b0;
        state_d     = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      req_valid <= 1'b0;
      req_floor <= '0;
      dir_up    <= 1'b1;
    end else begin
      state_q   <= state_d;
      req_valid <= req_valid_d;
      req_floor <= req_floor_d;
      dir_up    <= dir_up_d;
    end
  end

endmodule

// File: tb/tb_elevator_call_panel.sv
// Directed bench for elevator_call_panel; stimulus pushes expected handshakes/serves, a monitor checks them.
module tb_elevator_call_panel;
  import elevator_pkg::*;

  localparam int NF = DEF_NUM_FLOORS;
  localparam int FW = DEF_FLOOR_W;
`ifdef CALL_PANEL_DEBOUNCE_EN
  localparam int DB = DEF_DEBOUNCE_CYCLES;
`else
  localparam int DB = 0;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [NF-1:0] btn = '0;
  logic [FW-1:0] cur_floor = '0;
  logic          at_floor = 1'b0;
  logic          req_ready = 1'b0;
  logic          req_valid;
  logic [FW-1:0] req_floor;
  logic          dir_up;
  logic [NF-1:0] pending;
  logic          served;
  logic [FW-1:0] served_floor;

  int n_checks = 0;
  int n_fail = 0;
  logic [FW:0]   exp_req_q[$];
  logic [FW-1:0] exp_srv_q[$];

  elevator_call_panel dut (
    .clk          (clk),
    .reset        (reset),
    .btn          (btn),
    .cur_floor    (cur_floor),
    .at_floor     (at_floor),
    .req_ready    (req_ready),
    .req_valid    (req_valid),
    .req_floor    (req_floor),
    .dir_up       (dir_up),
    .pending      (pending),
    .served       (served),
    .served_floor (served_floor)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: got no end of test, expected finish before 100000");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name, input string detail);
    n_checks++;
    n_fail++;
    $display("FAIL %s: %s", name, detail);
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [NF-1:0] m);
    btn = btn | m;
    tick(DB + 1);
    btn = btn & ~m;
  endtask

  // Controller side: wait for an offer, then accept it for one cycle.
  task automatic accept(input logic [FW-1:0] fl, input logic up);
    int waited;
    waited = 0;
    exp_req_q.push_back({up, fl});
    @(negedge clk);
    while (!req_valid && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    if (!req_valid) begin
      void'(exp_req_q.pop_back());
      fail("req_timeout", $sformatf("got req_valid=0 for 20 cycles, expected offer of floor %0d", fl));
    end else begin
      @(posedge clk);
      #1 req_ready = 1'b1;
      @(posedge clk);
      #1 req_ready = 1'b0;
    end
  endtask

  task automatic arrive(input logic [FW-1:0] fl, input logic expect_served);
    if (expect_served) exp_srv_q.push_back(fl);
    cur_floor = fl;
    at_floor  = 1'b1;
    tick();
    at_floor  = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_pending"},      pending, 0);
    check({tag, "_req_valid"},    req_valid, 0);
    check({tag, "_req_floor"},    req_floor, 0);
    check({tag, "_dir_up"},       dir_up, 1);
    check({tag, "_served"},       served, 0);
    check({tag, "_served_floor"}, served_floor, 0);
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (req_valid && req_ready) begin
        if (exp_req_q.size() == 0)
          fail("req_unexpected", $sformatf("got handshake floor %0d, expected none", req_floor));
        else
          check("req_handshake", {dir_up, req_floor}, exp_req_q.pop_front());
      end
      if (served) begin
        if (exp_srv_q.size() == 0)
          fail("served_unexpected", $sformatf("got served floor %0d, expected none", served_floor));
        else
          check("served_floor", served_floor, exp_srv_q.pop_front());
      end
    end
  end

  initial begin
    reset = 1'b1;
    tick(3);
    reset = 1'b0;
    @(negedge clk);
    check_reset_values("rst");

    // Press at floor 0: lamp next edge, offer the edge after.
    tick();
    press(5'b01000);
    @(negedge clk);
    check("t1_pending", pending, 5'b01000);
    check("t1_valid_early", req_valid, 0);
    tick();
    @(negedge clk);
    check("t1_req_valid", req_valid, 1);
    check("t1_req_floor", req_floor, 3);
    check("t1_dir_up", dir_up, 1);

    // Offer held while ready is low.
    for (int i = 0; i < 5; i++) begin
      tick();
      @(negedge clk);
      check("t2_hold_valid", req_valid, 1);
      check("t2_hold_floor", req_floor, 3);
    end
    tick();
    accept(3, 1'b1);
    @(negedge clk);
    check("t2_valid_drop", req_valid, 0);
    tick();
    arrive(3, 1'b1);
    @(negedge clk);
    check("t2_pending_clr", pending, 0);
    check("t2_served", served, 1);
    tick();
    @(negedge clk);
    check("t2_served_pulse", served, 0);

    // SCAN: from floor 2 going up with {0,1,4} pending -> 4, then down 1, 0.
    tick();
    cur_floor = 2;
    press(5'b10011);
    @(negedge clk);
    check("t3_pending", pending, 5'b10011);
    tick();
    accept(4, 1'b1);
    arrive(4, 1'b1);
    accept(1, 1'b0);
    @(negedge clk);
    check("t3_dir_down", dir_up, 0);
    tick();
    arrive(1, 1'b1);
    accept(0, 1'b0);
    arrive(0, 1'b0 | 1'b1);
    @(negedge clk);
    check("t3_pending_empty", pending, 0);

    // Held button sets its lamp once only.
    tick();
    btn[2] = 1'b1;
    accept(2, 1'b1);
    arrive(2, 1'b1);
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      check("t4_held_pending", pending, 0);
      check("t4_held_valid", req_valid, 0);
      tick();
    end
    btn[2] = 1'b0;
    tick(2);
    press(5'b00100);
    @(negedge clk);
    check("t4_repress", pending, 5'b00100);
    tick();
    accept(2, 1'b1);
    arrive(2, 1'b1);

    // Press and arrival at the same floor in the same cycle: clear wins.
    btn[2] = 1'b1;
    tick(DB);
    exp_srv_q.push_back(3'd2);
    at_floor = 1'b1;
    tick();
    at_floor = 1'b0;
    @(negedge clk);
    check("t5_pending", pending, 0);
    check("t5_served", served, 1);
    tick();
    btn[2] = 1'b0;
    tick(3);
    @(negedge clk);
    check("t5_no_req", req_valid, 0);

    // Reset while waiting for arrival with several lamps lit.
    tick();
    press(5'b10110);
    @(negedge clk);
    check("t6_pending", pending, 5'b10110);
    tick();
    accept(2, 1'b1);
    @(negedge clk);
    check("t6_pending_wait", pending, 5'b10110);
    tick();
    reset = 1'b1;
    tick();
    @(negedge clk);
    check_reset_values("t6_rst");
    tick();
    reset = 1'b0;

    // Three-cycle glitch on floor 1: a press without debounce, ignored with it.
    btn[1] = 1'b1;
    tick(3);
    btn[1] = 1'b0;
    tick(DB + 2);
    @(negedge clk);
    check("glitch_pending", pending, (DB > 0) ? 5'b00000 : 5'b00010);

    check("exp_req_q_empty", exp_req_q.size(), 0);
    check("exp_srv_q_empty", exp_srv_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
